// File: rtl/mips_mem_pkg.sv
// Shared constants for the data-side memory responder: MMIO window decode,
// register offsets and STATUS bit layout.
package mips_mem_pkg;

  localparam logic [15:0] MMIO_BASE = 16'hFFFF;

  localparam logic [7:0] OFF_COUNT  = 8'h00;
  localparam logic [7:0] OFF_CMP    = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_TXDATA = 8'h0C;
  localparam logic [7:0] OFF_CLR    = 8'h10;

  localparam int unsigned ST_FULL   = 0;
  localparam int unsigned ST_EMPTY  = 1;
  localparam int unsigned ST_MATCH  = 2;
  localparam int unsigned ST_OVF    = 3;
  localparam int unsigned ST_OCC_LO = 4;

  localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

  // Assemble the STATUS word from its individual fields.
  function automatic logic [31:0] status_word(input logic full,
                                              input logic empty,
                                              input logic match,
                                              input logic ovf,
                                              input logic [3:0] occ);
    logic [31:0] w;
    w                     = '0;
    w[ST_FULL]            = full;
    w[ST_EMPTY]           = empty;
    w[ST_MATCH]           = match;
    w[ST_OVF]             = ovf;
    w[ST_OCC_LO+3:ST_OCC_LO] = occ;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered head output and occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign dout  = mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (do_push && !do_pop) begin
        cnt <= cnt + CW'(1);
      end else if (do_pop && !do_push) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data memory for the single-cycle MIPS core: word RAM plus an MMIO window
// holding a free-running counter with compare interrupt and a transmit FIFO.
module dmem_mmio
  import mips_mem_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        irq
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  logic          mmio_sel;
  logic [7:0]    off;
  logic          ram_we;
  logic          cmp_we;
  logic          tx_we;
  logic          clr_we;

  logic [31:0]   count;
  logic [31:0]   cmp;
  logic          match_flag;
  logic          overflow;

  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [CW-1:0] fifo_count;
  logic [3:0]    occ;
  logic          ovf_event;
  logic          unused_addr;

  assign mmio_sel = (addr[31:16] == MMIO_BASE);
  assign off      = addr[7:0];
  assign ram_idx  = addr[AW+1:2];

  assign ram_we = memwrite && !mmio_sel;
  assign cmp_we = memwrite && mmio_sel && (off == OFF_CMP);
  assign tx_we  = memwrite && mmio_sel && (off == OFF_TXDATA);
  assign clr_we = memwrite && mmio_sel && (off == OFF_CLR);

  assign unused_addr = ^{addr[15:8], addr[1:0]};

  assign out_valid = !fifo_empty;
  assign fifo_pop  = out_valid && out_ready;
  assign ovf_event = tx_we && fifo_full && !fifo_pop;
  assign occ       = 4'(fifo_count);
  assign irq       = match_flag;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_txfifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_we),
    .pop   (fifo_pop),
    .din   (writedata),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Word RAM write port; contents are never reset and a store under reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && ram_we) begin
      ram[ram_idx] <= writedata;
    end
  end

  // Cycle counter and compare register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      cmp   <= CMP_RESET;
    end else begin
      count <= count + 32'd1;
      if (cmp_we) begin
        cmp <= writedata;
      end
    end
  end

  // Sticky flags: the clear is applied first so a same-cycle set overrides it.
  always_ff @(posedge clk) begin
    if (reset) begin
      match_flag <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (clr_we) begin
        match_flag <= 1'b0;
        overflow   <= 1'b0;
      end
      if (count == cmp) begin
        match_flag <= 1'b1;
      end
      if (ovf_event) begin
        overflow <= 1'b1;
      end
    end
  end

  // Load path: combinational from the address.
  always_comb begin
    readdata = '0;
    if (mmio_sel) begin
      case (off)
        OFF_COUNT:  readdata = count;
        OFF_CMP:    readdata = cmp;
        OFF_STATUS: readdata = status_word(fifo_full, fifo_empty, match_flag, overflow, occ);
        default:    readdata = '0;
      endcase
    end else begin
      readdata = ram[ram_idx];
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed self-checking bench for dmem_mmio.
module tb_dmem_mmio;

  localparam logic [31:0] A_COUNT  = 32'hFFFF_0000;
  localparam logic [31:0] A_CMP    = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_000C;
  localparam logic [31:0] A_CLR    = 32'hFFFF_0010;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        irq;

  int checks;
  int failures;

  dmem_mmio #(
    .RAM_WORDS  (64),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    memwrite = 1'b0;
    step();
    reset    = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] d);
    memwrite = 1'b0;
    addr     = a;
    #1;
    d = readdata;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    addr      = a;
    writedata = d;
    step();
    memwrite  = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    load(A_COUNT, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_count got=%h exp=%h", d, 32'h0); end
    load(A_CMP, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_cmp got=%h exp=%h", d, 32'hFFFF_FFFF); end
    load(A_STATUS, d);
    checks++; if (d !== 32'h02) begin failures++; $display("FAIL reset_status got=%h exp=%h", d, 32'h02); end
    checks++; if ({out_valid, irq} !== 2'b00) begin failures++; $display("FAIL reset_valid_irq got=%b exp=%b", {out_valid, irq}, 2'b00); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=%h", out_data, 32'h0); end
  endtask

  task automatic test_ram();
    logic [31:0] d;
    store(32'h0000_0010, 32'hDEAD_BEEF);
    load(32'h0000_0010, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_rd got=%h exp=%h", d, 32'hDEAD_BEEF); end
    load(32'h0000_0110, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_alias got=%h exp=%h", d, 32'hDEAD_BEEF); end
    load(32'h0000_0013, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_lowbits got=%h exp=%h", d, 32'hDEAD_BEEF); end
    store(32'h0000_0040, 32'h1234_5678);
    store(32'hFFFF_0040, 32'h0000_0BAD);
    load(32'h0000_0040, d);
    checks++; if (d !== 32'h1234_5678) begin failures++; $display("FAIL ram_mmio_iso got=%h exp=%h", d, 32'h1234_5678); end
    load(32'hFFFF_0040, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL unmapped_rd got=%h exp=%h", d, 32'h0); end
    load(A_TXDATA, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL txdata_rd got=%h exp=%h", d, 32'h0); end
    load(A_CLR, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL clr_rd got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_counter();
    logic [31:0] d;
    do_reset();
    repeat (7) step();
    load(A_COUNT, d);
    checks++; if (d !== 32'd7) begin failures++; $display("FAIL count_n got=%0d exp=%0d", d, 7); end
    store(A_COUNT, 32'h0000_1234);
    load(A_COUNT, d);
    checks++; if (d !== 32'd8) begin failures++; $display("FAIL count_ro got=%0d exp=%0d", d, 8); end
  endtask

  task automatic test_compare();
    logic [31:0] d;
    logic [31:0] c;
    do_reset();
    store(A_CMP, 32'd20);
    load(A_CMP, d);
    checks++; if (d !== 32'd20) begin failures++; $display("FAIL cmp_rd got=%h exp=%h", d, 32'd20); end
    repeat (19) step();
    load(A_COUNT, d);
    checks++; if ({d, irq} !== {32'd20, 1'b0}) begin failures++; $display("FAIL cmp_before got=%0d/%b exp=20/0", d, irq); end
    step();
    load(A_COUNT, d);
    checks++; if ({d, irq} !== {32'd21, 1'b1}) begin failures++; $display("FAIL cmp_rise got=%0d/%b exp=21/1", d, irq); end
    repeat (19) step();
    load(A_COUNT, d);
    checks++; if ({d, irq} !== {32'd40, 1'b1}) begin failures++; $display("FAIL cmp_sticky got=%0d/%b exp=40/1", d, irq); end
    store(A_CLR, 32'h0);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL cmp_clr got=%b exp=%b", irq, 1'b0); end
    load(A_COUNT, c);
    store(A_CMP, c + 32'd1);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL cmp_pre_eq got=%b exp=%b", irq, 1'b0); end
    store(A_CLR, 32'h0);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL set_wins got=%b exp=%b", irq, 1'b1); end
    load(A_STATUS, d);
    checks++; if (d !== 32'h06) begin failures++; $display("FAIL set_wins_status got=%h exp=%h", d, 32'h06); end
    store(A_CLR, 32'h0);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL cmp_clr2 got=%b exp=%b", irq, 1'b0); end
  endtask

  task automatic test_fifo_order();
    logic [31:0] d;
    logic [31:0] exp_q [4];
    exp_q[0] = 32'hA000_000A;
    exp_q[1] = 32'hB000_000B;
    exp_q[2] = 32'hC000_000C;
    exp_q[3] = 32'hD000_000D;
    do_reset();
    out_ready = 1'b0;
    // No same-cycle bypass: out_valid stays low while the first push is pending.
    memwrite = 1'b1; addr = A_TXDATA; writedata = exp_q[0];
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL no_bypass got=%b exp=%b", out_valid, 1'b0); end
    step();
    memwrite = 1'b0;
    for (int i = 1; i < 4; i++) store(A_TXDATA, exp_q[i]);
    load(A_STATUS, d);
    checks++; if (d !== 32'h41) begin failures++; $display("FAIL fifo_full_status got=%h exp=%h", d, 32'h41); end
    store(A_TXDATA, 32'hEEEE_EEEE);
    load(A_STATUS, d);
    checks++; if (d !== 32'h49) begin failures++; $display("FAIL fifo_ovf_status got=%h exp=%h", d, 32'h49); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({out_valid, out_data} !== {1'b1, exp_q[i]}) begin
        failures++;
        $display("FAIL fifo_order[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, exp_q[i]);
      end
      step();
    end
    load(A_STATUS, d);
    checks++; if ({out_valid, d} !== {1'b0, 32'h0A}) begin failures++; $display("FAIL fifo_drained got=%b/%h exp=0/%h", out_valid, d, 32'h0A); end
    out_ready = 1'b0;
    store(A_CLR, 32'h0);
    load(A_STATUS, d);
    checks++; if (d !== 32'h02) begin failures++; $display("FAIL ovf_clr got=%h exp=%h", d, 32'h02); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [31:0] exp_q [5];
    exp_q[0] = 32'h1111_0001;
    exp_q[1] = 32'h2222_0002;
    exp_q[2] = 32'h3333_0003;
    exp_q[3] = 32'h4444_0004;
    exp_q[4] = 32'h5555_0005;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(A_TXDATA, exp_q[i]);
    checks++; if (out_data !== exp_q[0]) begin failures++; $display("FAIL b2b_head_stable got=%h exp=%h", out_data, exp_q[0]); end
    out_ready = 1'b1;
    store(A_TXDATA, exp_q[4]);
    load(A_STATUS, d);
    checks++; if (d !== 32'h41) begin failures++; $display("FAIL b2b_status got=%h exp=%h", d, 32'h41); end
    for (int i = 1; i < 5; i++) begin
      #1;
      checks++;
      if ({out_valid, out_data} !== {1'b1, exp_q[i]}) begin
        failures++;
        $display("FAIL b2b_order[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, exp_q[i]);
      end
      step();
    end
    load(A_STATUS, d);
    checks++; if (d !== 32'h02) begin failures++; $display("FAIL b2b_end_status got=%h exp=%h", d, 32'h02); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    logic [31:0] d;
    logic [31:0] c;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(A_TXDATA, 32'h7700_0000 + 32'(i));
    store(32'h0000_0020, 32'h0000_0011);
    load(A_COUNT, c);
    store(A_CMP, c + 32'd1);
    step();
    load(A_STATUS, d);
    checks++; if ({irq, d} !== {1'b1, 32'h34}) begin failures++; $display("FAIL midop_pre got=%b/%h exp=1/%h", irq, d, 32'h34); end
    reset     = 1'b1;
    memwrite  = 1'b1;
    addr      = 32'h0000_0020;
    writedata = 32'h0000_0055;
    step();
    reset     = 1'b0;
    memwrite  = 1'b0;
    checks++; if ({out_valid, irq} !== 2'b00) begin failures++; $display("FAIL midop_valid_irq got=%b exp=%b", {out_valid, irq}, 2'b00); end
    load(A_STATUS, d);
    checks++; if (d !== 32'h02) begin failures++; $display("FAIL midop_status got=%h exp=%h", d, 32'h02); end
    load(A_COUNT, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL midop_count got=%h exp=%h", d, 32'h0); end
    load(32'h0000_0020, d);
    checks++; if (d !== 32'h0000_0011) begin failures++; $display("FAIL midop_store_dropped got=%h exp=%h", d, 32'h11); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    memwrite  = 1'b0;
    addr      = '0;
    writedata = '0;
    out_ready = 1'b0;
    test_reset();
    test_ram();
    test_counter();
    test_compare();
    test_fifo_order();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
